// File: rtl/sisc_fetch.sv
// Purpose: instruction fetch front end for the sisc core with 2-entry prefetch and branch redirect.
// Latency: request is driven in the FETCH cycle; an acked word reaches ir on the cycle after imem_ack.
// Backpressure: ir_ready low holds the FIFO head; no new request is issued while both slots are full.
//
// Ports:
//   clk, rst_f              clock (rising edge) and asynchronous active-low reset
//   imem_req/imem_addr      word-address read request, held until imem_ack
//   imem_ack/imem_rdata     memory response; acks without an outstanding request are ignored
//   ir/ir_pc/ir_valid       FIFO head toward the control unit (zero when empty)
//   ir_ready                consumer accepts ir this cycle (handoff = ir_valid & ir_ready)
//   br_take/br_addr         single-cycle redirect: flush prefetch, restart fetch at br_addr
//   halted                  a HALT word has been handed off (sticky until reset)
//
// Optional feature macro: SISC_FETCH_HALT_EN
//   defined   : a fetched word with opcode 4'hF stops fetching; its handoff sets halted,
//               and redirects are ignored once halted.
//   undefined : opcode 4'hF is an ordinary instruction and halted is tied low.

module sisc_fetch (
  input  logic        clk,
  input  logic        rst_f,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_take,
  input  logic [15:0] br_addr,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] word;
  } fq_entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;   // address of the outstanding request
  logic        discard_q, discard_d;     // drop the ack of a request made stale by a redirect

  fq_entry_t   fq_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  // ---------------------------------------------------------------------------
  // Control strobes
  // ---------------------------------------------------------------------------
  logic        handoff;
  logic        redirect;
  logic        is_halt_word;
  logic        req_c;
  logic        push;
  logic        flush;
  fq_entry_t   head;
  fq_entry_t   push_entry;

  assign head       = fq_q[rd_ptr_q];
  assign ir_valid   = (count_q != 2'd0);
  assign ir         = ir_valid ? head.word : 32'h0000_0000;
  assign ir_pc      = ir_valid ? head.addr : 16'h0000;
  assign handoff    = ir_valid & ir_ready;

  assign push_entry = '{addr: req_addr_q, word: imem_rdata};

`ifdef SISC_FETCH_HALT_EN
  logic halted_q;

  assign is_halt_word = (imem_rdata[31:28] == 4'hF);
  // Once the HALT word has been consumed the front end is frozen until reset.
  assign redirect     = br_take & ~halted_q;
  assign halted       = halted_q;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      halted_q <= 1'b0;
    end else if (handoff && (ir[31:28] == 4'hF)) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign is_halt_word = 1'b0;
  assign redirect     = br_take;
  assign halted       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    req_c      = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          // Do not launch a request for the old PC; the target goes out next cycle.
          flush = 1'b1;
          pc_d  = br_addr;
        end else if (count_q != 2'd2) begin
          // Nothing is pending in FETCH, so a free slot is just count < 2.
          req_c      = 1'b1;
          req_addr_d = pc_q;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        req_c = 1'b1;
        if (redirect) begin
          flush = 1'b1;
          pc_d  = br_addr;
          if (imem_ack) begin
            // Response arrives with the redirect: consume and drop it here.
            discard_d = 1'b0;
            state_d   = ST_FETCH;
          end else begin
            // Request stays on the bus until acked; mark its data stale.
            discard_d = 1'b1;
          end
        end else if (imem_ack) begin
          discard_d = 1'b0;
          state_d   = ST_FETCH;
          if (!discard_q) begin
            push = 1'b1;
            pc_d = pc_q + 16'd1;
            if (is_halt_word) begin
              state_d = ST_STOP;
            end
          end
        end
      end

      ST_STOP: begin
        // A redirect before the HALT word is consumed flushes it and resumes fetch.
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = br_addr;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Gate with reset so the bus is idle while rst_f is low even though the
  // reset state (FETCH, empty FIFO) would otherwise request immediately.
  assign imem_req  = rst_f & req_c;
  assign imem_addr = (state_q == ST_WAIT) ? req_addr_q : pc_q;

  // ---------------------------------------------------------------------------
  // FSM / PC registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= ST_FETCH;
      pc_q       <= 16'h0000;
      req_addr_q <= 16'h0000;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry prefetch FIFO. A handoff in the same cycle as a flush is simply
  // absorbed by the flush. Push with pop while full writes the slot being
  // read; the head has already been presented combinationally this cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      fq_q[0]  <= '0;
      fq_q[1]  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fq_q[wr_ptr_q] <= push_entry;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (handoff) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, handoff})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: random memory latency, backpressure and redirects,
// checked against an instruction-stream scoreboard (consecutive word addresses
// restarting at every redirect target).
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_take;
  logic [15:0] br_addr;
  logic        halted;

  always #5 clk = ~clk;

  sisc_fetch dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_take   (br_take),
    .br_addr   (br_addr),
    .halted    (halted)
  );

  typedef struct {
    logic [15:0] pc;
    logic [31:0] word;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hand_cnt = 0;
  exp_t        exp_q[$];
  logic [15:0] exp_pc = 16'h0000;
  bit          halt_word_en = 1'b0;
  bit          model_halted = 1'b0;
  int          fhand_cyc = -1;
  int          halted_cyc = -1;
  logic [15:0] hand_log[$];

  // memory model
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = 16'h0000;
  int          lat_min = 1;
  int          lat_max = 1;
  int          spur_pct = 0;
  logic [15:0] newreq_log[$];
  int          max_req_addr = 0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (halt_word_en && a == 16'h0005) return 32'hF000_0000;
    return 32'h8801_0001 + {16'h0000, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: latches a new request, acks it after lat_min..lat_max cycles and
  // checks that the request is held with a stable address meanwhile.
  task automatic mem_step();
    if (!rst_f) begin
      mem_busy = 1'b0;
      imem_ack = 1'b0;
    end else if (mem_busy) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", {16'h0, imem_addr}, {16'h0, mem_addr});
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(mem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack = 1'b0;
      end
    end else if (imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
      imem_ack = 1'b0;
      newreq_log.push_back(imem_addr);
      if (int'(imem_addr) > max_req_addr) max_req_addr = int'(imem_addr);
    end else begin
      // Stray acks with junk data while nothing is requested.
      imem_ack   = ($urandom_range(99, 0) < spur_pct);
      imem_rdata = $urandom();
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
    prev_ack  = imem_ack;
  endtask

  // Stream model: a redirect (unless halted) restarts the expected stream.
  task automatic model_update();
    if (br_take && !model_halted) begin
      exp_q.delete();
      exp_pc = br_addr;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back('{exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 16'd1;
    end
  endtask

  task automatic step(input logic rdy, input logic br, input logic [15:0] ba);
    @(negedge clk);
    ir_ready = rdy;
    br_take  = br;
    br_addr  = ba;
    #1 mem_step();
    #2 model_update();
    cyc++;
  endtask

  task automatic run(input int n, input int rdy_pct);
    for (int i = 0; i < n; i++) step($urandom_range(99, 0) < rdy_pct, 1'b0, 16'h0000);
  endtask

  task automatic apply_reset(input logic rdy);
    @(negedge clk);
    #1;
    rst_f    = 1'b0;
    br_take  = 1'b0;
    ir_ready = 1'b0;
    imem_ack = 1'b0;
    mem_busy = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", {16'h0, imem_addr}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_pc", {16'h0, ir_pc}, 32'd0);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    exp_q.delete();
    exp_pc       = 16'h0000;
    model_halted = 1'b0;
    fhand_cyc    = -1;
    halted_cyc   = -1;
    hand_log.delete();
    newreq_log.delete();
    max_req_addr = 0;
    repeat (2) @(negedge clk);
    rst_f    = 1'b1;
    ir_ready = rdy;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", {16'h0, imem_addr}, 32'd0);
    mem_step();
    #2 model_update();
    cyc++;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (rst_f) begin
      if (halted === 1'b1 && halted_cyc < 0) halted_cyc = cyc;
      if (!ir_valid) begin
        chk("ir_empty", ir, 32'd0);
        chk("ir_pc_empty", {16'h0, ir_pc}, 32'd0);
      end else if (ir_ready) begin
        chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_pc", {16'h0, ir_pc}, {16'h0, e.pc});
          chk("sb_word", ir, e.word);
        end
        hand_cnt++;
        hand_log.push_back(ir_pc);
        if (ir[31:28] == 4'hF) begin
          fhand_cyc = cyc;
`ifdef SISC_FETCH_HALT_EN
          model_halted = 1'b1;
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int h0, n0, cnt;
    bit found;
    rst_f = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    ir_ready = 1'b0; br_take = 1'b0; br_addr = '0;

    // Basic stream from reset, single-cycle memory
    lat_min = 1; lat_max = 1; spur_pct = 0;
    apply_reset(1'b1);
    run(12, 100);
    chk("pc_seq_len", {31'b0, hand_log.size() >= 4}, 32'd1);
    if (hand_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("pc_seq", {16'h0, hand_log[i]}, i);

    // Throughput: one handoff every two cycles
    h0 = hand_cnt;
    run(40, 100);
    chk("throughput", hand_cnt - h0, 32'd20);

    // Stall: FIFO fills with two words, then requests stop
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0000);
      if (i >= 4 && prev_req) cnt++;
    end
    chk("stall_no_req", cnt, 32'd0);
    h0 = hand_cnt;
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    chk("stall_drain2", hand_cnt - h0, 32'd2);
    run(10, 100);

    // Redirect while waiting on 0x0003
    apply_reset(1'b1);
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (prev_req && prev_addr == 16'h0003 && !prev_ack) found = 1'b1;
      else step(1'b1, 1'b0, 16'h0000);
    end
    chk("reach_wait3", {31'b0, found}, 32'd1);
    if (found) begin
      n0 = newreq_log.size();
      step(1'b1, 1'b1, 16'h0040);
      h0 = hand_log.size();
      run(20, 100);
      chk("br_have_req", {31'b0, newreq_log.size() > n0}, 32'd1);
      if (newreq_log.size() > n0) chk("br_next_addr", {16'h0, newreq_log[n0]}, 32'h40);
      chk("br_have_hand", {31'b0, hand_log.size() > h0}, 32'd1);
      if (hand_log.size() > h0) chk("br_next_pc", {16'h0, hand_log[h0]}, 32'h40);
    end

    // Wrap: 0xFFFF then 0x0000
    lat_min = 1; lat_max = 2;
    n0 = newreq_log.size();
    step(1'b1, 1'b1, 16'hFFFF);
    run(20, 100);
    chk("wrap_len", {31'b0, newreq_log.size() >= n0 + 2}, 32'd1);
    if (newreq_log.size() >= n0 + 2) begin
      chk("wrap_first", {16'h0, newreq_log[n0]}, 32'hFFFF);
      chk("wrap_second", {16'h0, newreq_log[n0 + 1]}, 32'h0000);
    end

    // HALT opcode at 0x0005
    halt_word_en = 1'b1;
    lat_min = 1; lat_max = 1;
    apply_reset(1'b1);
    run(30, 100);
`ifdef SISC_FETCH_HALT_EN
    chk("halt_max_addr", max_req_addr, 32'd5);
    chk("halted", {31'b0, halted}, 32'd1);
    chk("halt_timing", halted_cyc, fhand_cyc + 1);
    n0 = newreq_log.size();
    step(1'b1, 1'b1, 16'h0020);
    run(5, 100);
    chk("halt_br_ignored", newreq_log.size() - n0, 32'd0);
    chk("halt_held", {31'b0, halted}, 32'd1);
`else
    chk("nohalt_continue", {31'b0, max_req_addr >= 6}, 32'd1);
    chk("nohalt_flag", {31'b0, halted}, 32'd0);
`endif
    halt_word_en = 1'b0;

    // Reset pulse while waiting on 0x0010
    apply_reset(1'b1);
    lat_min = 3; lat_max = 3;
    step(1'b1, 1'b1, 16'h0010);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (prev_req && prev_addr == 16'h0010 && !prev_ack) found = 1'b1;
      else step(1'b1, 1'b0, 16'h0000);
    end
    chk("reach_wait10", {31'b0, found}, 32'd1);
    apply_reset(1'b1);
    run(10, 100);

    // Random traffic
    lat_min = 1; lat_max = 3; spur_pct = 10;
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ba;
      ba = ($urandom_range(3, 0) == 0) ? (16'hFFFF - 16'($urandom_range(2, 0)))
                                       : 16'($urandom());
      step($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 5, ba);
    end
    spur_pct = 0;
    h0 = hand_cnt;
    run(20, 100);
    chk("progress", {31'b0, (hand_cnt - h0) >= 5}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
